// File: rtl/grey_pkg.sv
// Shared types, code table and digit helpers for the two-digit Gray-style
// counter decoder.
//   state_t      : decoder state (no baseline yet / tracking a baseline)
//   bcd_pair_t   : tens/ones BCD pair used as the tracked baseline
//   CODE_TABLE   : 5-bit code for each decimal digit 0..9
//   digit_decode : 5-bit code -> BCD digit, BCD_ILLEGAL when not in the table
//   digit_succ   : next decimal digit, 9 wraps to 0
package grey_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned NUM_DIGITS = 10;

  localparam logic [BCD_W-1:0] BCD_ILLEGAL = 4'hF;
  localparam logic [BCD_W-1:0] BCD_NINE    = 4'd9;
  localparam logic [CNT_W-1:0] CNT_ILLEGAL = 7'h7F;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;

  // One bit changes between neighbouring digits.
  localparam logic [CODE_W-1:0] CODE_TABLE [NUM_DIGITS] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
    5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000
  };

  function automatic logic [BCD_W-1:0] digit_decode(input logic [CODE_W-1:0] code);
    logic [BCD_W-1:0] bcd;
    bcd = BCD_ILLEGAL;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (code == CODE_TABLE[i]) bcd = BCD_W'(i);
    end
    return bcd;
  endfunction

  function automatic logic [BCD_W-1:0] digit_succ(input logic [BCD_W-1:0] bcd);
    return (bcd == BCD_NINE) ? '0 : BCD_W'(bcd + 4'd1);
  endfunction

endpackage

// File: rtl/grey_digit_dec.sv
// Combinational decode of one 5-bit digit code.
//   i_code    : 5-bit Gray-style digit code
//   o_legal_c : code is one of the ten table entries
//   o_bcd_c   : decoded BCD digit, 4'hF when illegal
module grey_digit_dec
  import grey_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic              o_legal_c,
  output logic [BCD_W-1:0]  o_bcd_c
);

  always_comb begin
    o_bcd_c   = digit_decode(i_code);
    o_legal_c = (o_bcd_c != BCD_ILLEGAL);
  end

endmodule

// File: rtl/grey_count_decoder.sv
// Receive-side decoder for the two-digit Gray-style counter code. Samples the
// digit codes on i_sample, outputs BCD and binary count one cycle later, and
// checks each sample against the code set and the successor of the baseline.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_sample            : sample i_ones/i_tens this cycle
//   i_ones, i_tens      : 5-bit digit codes
//   i_clr_err           : clear sticky error flags (a new error wins)
//   o_ones_bcd/tens_bcd : decoded digits, 4'hF when illegal
//   o_count             : tens*10+ones, 7'h7F when either digit illegal
//   o_valid             : one-cycle pulse, outputs updated from a sample
//   o_err_code/err_seq  : sticky illegal-code / bad-sequence flags
//   o_locked            : LOCK_STEPS consecutive legal steps seen
module grey_count_decoder
  import grey_pkg::*;
#(
  parameter int unsigned LOCK_STEPS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sample,
  input  logic [4:0]       i_ones,
  input  logic [4:0]       i_tens,
  input  logic             i_clr_err,
  output logic [3:0]       o_ones_bcd,
  output logic [3:0]       o_tens_bcd,
  output logic [6:0]       o_count,
  output logic             o_valid,
  output logic             o_err_code,
  output logic             o_err_seq,
  output logic             o_locked
);

  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LOCK_STEPS);

  state_t              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  bcd_pair_t           r_base, w_base_nxt;
  logic [BCD_W-1:0]    r_ones_bcd, r_tens_bcd;
  logic [CNT_W-1:0]    r_count;
  logic                r_valid, r_err_code, r_err_seq, r_locked;

  logic                w_ones_legal, w_tens_legal, w_legal;
  logic [BCD_W-1:0]    w_ones_bcd, w_tens_bcd;
  bcd_pair_t           w_sample, w_succ;
  logic [CNT_W-1:0]    w_count;
  logic                w_set_err_code, w_set_err_seq;

  grey_digit_dec u_ones_dec (
    .i_code    (i_ones),
    .o_legal_c (w_ones_legal),
    .o_bcd_c   (w_ones_bcd)
  );

  grey_digit_dec u_tens_dec (
    .i_code    (i_tens),
    .o_legal_c (w_tens_legal),
    .o_bcd_c   (w_tens_bcd)
  );

  // Sample decode, legal successor of the baseline, and binary count.
  always_comb begin
    w_legal       = w_ones_legal & w_tens_legal;
    w_sample.tens = w_tens_bcd;
    w_sample.ones = w_ones_bcd;
    w_succ.ones   = digit_succ(r_base.ones);
    w_succ.tens   = (r_base.ones == BCD_NINE) ? digit_succ(r_base.tens) : r_base.tens;
    w_count       = CNT_W'({w_tens_bcd, 3'b000}) + CNT_W'({w_tens_bcd, 1'b0})
                  + CNT_W'(w_ones_bcd);
  end

  // State register plus all datapath/output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_EMPTY;
      r_step     <= '0;
      r_base     <= '0;
      r_ones_bcd <= '0;
      r_tens_bcd <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_err_code <= 1'b0;
      r_err_seq  <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_base     <= w_base_nxt;
      r_valid    <= i_sample;
      r_err_code <= w_set_err_code | (r_err_code & ~i_clr_err);
      r_err_seq  <= w_set_err_seq  | (r_err_seq  & ~i_clr_err);
      r_locked   <= (w_step_nxt == STEP_MAX);
      if (i_sample) begin
        r_ones_bcd <= w_ones_bcd;
        r_tens_bcd <= w_tens_bcd;
        r_count    <= w_legal ? w_count : CNT_ILLEGAL;
      end
    end
  end

  // Next state: a legal sample establishes the baseline, an illegal one drops it.
  always_comb begin
    w_state_nxt = r_state;
    if (i_sample) begin
      case (r_state)
        S_EMPTY: if (w_legal)  w_state_nxt = S_TRACK;
        S_TRACK: if (!w_legal) w_state_nxt = S_EMPTY;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Step counter, baseline and error-set decisions for the current sample.
  always_comb begin
    w_step_nxt     = r_step;
    w_base_nxt     = r_base;
    w_set_err_code = 1'b0;
    w_set_err_seq  = 1'b0;
    if (i_sample) begin
      if (!w_legal) begin
        w_set_err_code = 1'b1;
        w_step_nxt     = '0;
      end else if (r_state == S_EMPTY) begin
        w_base_nxt = w_sample;
        w_step_nxt = '0;
      end else if (w_sample == r_base) begin
        // hold: nothing changes
      end else if (w_sample == w_succ) begin
        w_base_nxt = w_sample;
        if (r_step != STEP_MAX) w_step_nxt = STEP_W'(r_step + 4'd1);
      end else begin
        w_set_err_seq = 1'b1;
        w_step_nxt    = '0;
        w_base_nxt    = w_sample;
      end
    end
  end

  assign o_ones_bcd = r_ones_bcd;
  assign o_tens_bcd = r_tens_bcd;
  assign o_count    = r_count;
  assign o_valid    = r_valid;
  assign o_err_code = r_err_code;
  assign o_err_seq  = r_err_seq;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_grey_count_decoder.sv
module tb_grey_count_decoder;

  localparam int unsigned L = 4;

  logic       clk = 1'b0;
  logic       rst, smp, clr;
  logic [4:0] ones_c, tens_c;
  logic [3:0] o_ones_bcd, o_tens_bcd;
  logic [6:0] o_count;
  logic       o_valid, o_err_code, o_err_seq, o_locked;

  always #5 clk = ~clk;

  grey_count_decoder #(.LOCK_STEPS(L)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sample   (smp),
    .i_ones     (ones_c),
    .i_tens     (tens_c),
    .i_clr_err  (clr),
    .o_ones_bcd (o_ones_bcd),
    .o_tens_bcd (o_tens_bcd),
    .o_count    (o_count),
    .o_valid    (o_valid),
    .o_err_code (o_err_code),
    .o_err_seq  (o_err_seq),
    .o_locked   (o_locked)
  );

  logic [4:0] codes [10];
  int errors = 0;
  int checks = 0;

  // Reference model: baseline kept as a plain integer 0..99.
  int m_ones, m_tens, m_count, m_base, m_step;
  bit m_valid, m_ec, m_es, m_lk, m_has;

  typedef struct {
    bit smp;
    int tens_d;
    int ones_d;   // -1 selects the illegal code 00101
    bit clr;
    int cnt;
    bit valid;
    bit ec;
    bit es;
    bit lk;
  } vec_t;

  vec_t vt[$];

  function automatic int dec(input logic [4:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input logic [4:0] oc,
                            input logic [4:0] tc, input bit c);
    int o, t, v;
    bit set_ec, set_es;
    if (r) begin
      m_ones = 0; m_tens = 0; m_count = 0; m_valid = 0;
      m_ec = 0; m_es = 0; m_lk = 0; m_has = 0; m_base = 0; m_step = 0;
      return;
    end
    set_ec = 0; set_es = 0;
    m_valid = s;
    if (s) begin
      o = dec(oc);
      t = dec(tc);
      m_ones = (o < 0) ? 15 : o;
      m_tens = (t < 0) ? 15 : t;
      if (o < 0 || t < 0) begin
        m_count = 127;
        set_ec = 1; m_step = 0; m_has = 0;
      end else begin
        v = t * 10 + o;
        m_count = v;
        if (!m_has) begin
          m_has = 1; m_base = v;
        end else if (v == m_base) begin
        end else if (v == (m_base + 1) % 100) begin
          m_base = v;
          if (m_step < L) m_step++;
        end else begin
          set_es = 1; m_step = 0; m_base = v;
        end
      end
    end
    m_ec = set_ec ? 1'b1 : (c ? 1'b0 : m_ec);
    m_es = set_es ? 1'b1 : (c ? 1'b0 : m_es);
    m_lk = (m_step == L);
  endtask

  task automatic check_model();
    check("ones_bcd", int'(o_ones_bcd), m_ones);
    check("tens_bcd", int'(o_tens_bcd), m_tens);
    check("count",    int'(o_count),    m_count);
    check("valid",    int'(o_valid),    int'(m_valid));
    check("err_code", int'(o_err_code), int'(m_ec));
    check("err_seq",  int'(o_err_seq),  int'(m_es));
    check("locked",   int'(o_locked),   int'(m_lk));
  endtask

  task automatic drive(input bit r, input bit s, input logic [4:0] oc,
                       input logic [4:0] tc, input bit c);
    @(negedge clk);
    rst = r; smp = s; ones_c = oc; tens_c = tc; clr = c;
    @(posedge clk);
    #1;
    model_step(r, s, oc, tc, c);
    check_model();
  endtask

  task automatic send(input int v, input bit c);
    drive(1'b0, 1'b1, codes[v % 10], codes[v / 10], c);
  endtask

  initial begin
    logic [4:0] ill;
    int cur, r, ot, oo;

    codes[0] = 5'b00000; codes[1] = 5'b00001; codes[2] = 5'b00011;
    codes[3] = 5'b00010; codes[4] = 5'b00110; codes[5] = 5'b00100;
    codes[6] = 5'b01100; codes[7] = 5'b01000; codes[8] = 5'b11000;
    codes[9] = 5'b10000;

    rst = 1'b1; smp = 1'b0; clr = 1'b0; ones_c = '0; tens_c = '0;
    drive(1'b1, 1'b0, 5'b0, 5'b0, 1'b0);
    drive(1'b1, 1'b0, 5'b0, 5'b0, 1'b0);
    check("rst count", int'(o_count), 0);
    check("rst valid", int'(o_valid), 0);
    check("rst locked", int'(o_locked), 0);

    // Directed table: baseline, lock, illegal code, skip, clear, holds.
    vt.push_back('{1, 0, 0, 0,   0, 1, 0, 0, 0});
    vt.push_back('{1, 0, 1, 0,   1, 1, 0, 0, 0});
    vt.push_back('{1, 0, 2, 0,   2, 1, 0, 0, 0});
    vt.push_back('{1, 0, 3, 0,   3, 1, 0, 0, 0});
    vt.push_back('{1, 0, 4, 0,   4, 1, 0, 0, 1});
    vt.push_back('{1, 0, -1, 0, 127, 1, 1, 0, 0});
    vt.push_back('{1, 0, 7, 0,   7, 1, 1, 0, 0});
    vt.push_back('{1, 2, 3, 1,  23, 1, 0, 1, 0});
    vt.push_back('{1, 2, 3, 1,  23, 1, 0, 0, 0});
    vt.push_back('{1, 2, 5, 0,  25, 1, 0, 1, 0});
    vt.push_back('{1, 2, 6, 0,  26, 1, 0, 1, 0});
    vt.push_back('{1, 2, 7, 0,  27, 1, 0, 1, 0});
    vt.push_back('{1, 2, 8, 0,  28, 1, 0, 1, 0});
    vt.push_back('{1, 2, 9, 0,  29, 1, 0, 1, 1});
    vt.push_back('{1, 3, 0, 0,  30, 1, 0, 1, 1});
    vt.push_back('{0, 3, 0, 1,  30, 0, 0, 0, 1});
    vt.push_back('{1, 4, 7, 0,  47, 1, 0, 1, 0});
    vt.push_back('{1, 4, 7, 0,  47, 1, 0, 1, 0});
    vt.push_back('{1, 4, 7, 0,  47, 1, 0, 1, 0});
    vt.push_back('{1, 4, 8, 0,  48, 1, 0, 1, 0});
    vt.push_back('{1, 5, 0, 1,  50, 1, 0, 1, 0});
    vt.push_back('{0, 5, 0, 1,  50, 0, 0, 0, 0});

    drive(1'b0, 1'b0, 5'b0, 5'b0, 1'b0);
    foreach (vt[i]) begin
      drive(1'b0, vt[i].smp,
            (vt[i].ones_d < 0) ? 5'b00101 : codes[vt[i].ones_d],
            codes[vt[i].tens_d], vt[i].clr);
      check($sformatf("vec%0d count", i),    int'(o_count),    vt[i].cnt);
      check($sformatf("vec%0d valid", i),    int'(o_valid),    int'(vt[i].valid));
      check($sformatf("vec%0d err_code", i), int'(o_err_code), int'(vt[i].ec));
      check($sformatf("vec%0d err_seq", i),  int'(o_err_seq),  int'(vt[i].es));
      check($sformatf("vec%0d locked", i),   int'(o_locked),   int'(vt[i].lk));
    end

    // Full sweep 0..99 and wrap to 00.
    drive(1'b1, 1'b0, 5'b0, 5'b0, 1'b0);
    for (int v = 0; v < 100; v++) send(v, 1'b0);
    send(0, 1'b0);
    check("wrap count", int'(o_count), 0);
    check("wrap err_seq", int'(o_err_seq), 0);
    check("wrap locked", int'(o_locked), 1);

    // Reset mid-sweep overrides a sample; next sample is a fresh baseline.
    for (int v = 10; v < 16; v++) send(v, 1'b0);
    drive(1'b1, 1'b1, codes[6], codes[1], 1'b0);
    check("midrst count", int'(o_count), 0);
    check("midrst ones", int'(o_ones_bcd), 0);
    check("midrst tens", int'(o_tens_bcd), 0);
    check("midrst valid", int'(o_valid), 0);
    check("midrst locked", int'(o_locked), 0);
    send(55, 1'b0);
    check("rebase count", int'(o_count), 55);
    check("rebase err_seq", int'(o_err_seq), 0);

    // Randomized traffic against the model.
    cur = 55;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 199) == 0) begin
        drive(1'b1, 1'($urandom_range(0, 1)), codes[cur % 10], codes[cur / 10], 1'b0);
      end else if (r < 15) begin
        drive(1'b0, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 9) == 0));
      end else if (r < 88) begin
        if (r >= 80)      cur = $urandom_range(0, 99);
        else if (r >= 25) cur = (cur + 1) % 100;
        send(cur, 1'($urandom_range(0, 9) == 0));
      end else begin
        ill = 5'b00101;
        for (int k = 0; k < 20; k++) begin
          ill = 5'($urandom_range(0, 31));
          if (dec(ill) < 0) break;
        end
        if (dec(ill) >= 0) ill = 5'b11111;
        ot = $urandom_range(0, 2);
        oo = cur;
        if (ot == 0)      drive(1'b0, 1'b1, ill, codes[oo / 10], 1'($urandom_range(0, 1)));
        else if (ot == 1) drive(1'b0, 1'b1, codes[oo % 10], ill, 1'($urandom_range(0, 1)));
        else              drive(1'b0, 1'b1, ill, ill, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grey_count_decoder.md
# grey_count_decoder

Receive-side decoder for the two-digit, 5-bit-per-digit Gray-style counter code (ones and tens digits, each stepping 0..9 with one bit change per step). Samples the digit codes on a strobe, converts them to BCD and a binary count 0..99, and checks every sample against the legal code set and the legal successor of the previous sample. Sits between the pad inputs carrying the counter code and the display/check logic; all inputs are synchronous to i_clk.

## Interface
- LOCK_STEPS, default 4: consecutive legal successor steps required before o_locked asserts (range 1..15).
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_sample  in  1  strobe; sample i_ones/i_tens this cycle.
- i_ones  in  5  ones-digit code.
- i_tens  in  5  tens-digit code.
- i_clr_err  in  1  clears sticky error flags.
- o_ones_bcd  out  4  decoded ones digit; 4'hF if code illegal.
- o_tens_bcd  out  4  decoded tens digit; 4'hF if code illegal.
- o_count  out  7  tens*10+ones, 0..99; 7'h7F if either digit illegal.
- o_valid  out  1  one-cycle pulse; outputs updated from a sample.
- o_err_code  out  1  sticky; an illegal code was sampled.
- o_err_seq  out  1  sticky; a sample was neither hold nor legal successor.
- o_locked  out  1  LOCK_STEPS consecutive legal steps since last error/reset.

## Operation
- Code table, digit 0..9: 00000, 00001, 00011, 00010, 00110, 00100, 01100, 01000, 11000, 10000. The other 22 codes are illegal.
- Successor of (tens,ones): ones<9 → (tens, ones+1); ones==9 → (tens+1 mod 10, 0). 99 → 00 is legal.
- States: S_EMPTY (no baseline), S_TRACK.
  - S_EMPTY: a sample with both digits legal becomes the baseline → S_TRACK. No sequence check; step counter stays 0. An illegal sample sets o_err_code and stays in S_EMPTY.
  - S_TRACK, legal sample equal to baseline (hold): no error, step counter unchanged.
  - S_TRACK, legal successor: step counter +1, saturating at LOCK_STEPS; baseline updated.
  - S_TRACK, legal but any other value: o_err_seq set, step counter cleared, baseline set to the sample, stay in S_TRACK.
  - S_TRACK, illegal code in either digit: o_err_code set, step counter cleared → S_EMPTY.
- o_locked = (step counter == LOCK_STEPS); it drops on the cycle the clearing sample's outputs appear.
- Sticky flags hold until i_clr_err or i_rst. If i_clr_err is asserted in the same cycle as a new error, the new error wins and the flag stays set.
- Outputs hold their last value when i_sample is low.

## Timing
- Latency 1: sample at cycle N → o_valid, BCD, count, flags, o_locked updated at N+1.
- Back-to-back samples every cycle are supported. No backpressure.
- Reset values: o_ones_bcd=0, o_tens_bcd=0, o_count=0, o_valid=0, o_err_code=0, o_err_seq=0, o_locked=0. State=S_EMPTY, step counter=0, baseline=00.
- i_rst asserted mid-stream overrides i_sample that cycle. The next sample after reset is treated as a fresh baseline.

## Structure
- grey_pkg: state enum, the 10-entry code table as constants, digit-decode function (code→4-bit BCD, 4'hF illegal), and digit-successor function.
- Sub-module grey_digit_dec: combinational, 5-bit code → {legal, bcd[3:0]}. Instanced twice, once for ones and once for tens.
- Top holds the baseline registers, state, step counter, flags, output registers, and the binary multiply-add (tens*8 + tens*2 + ones).

## Test plan
- Reset, then sample 00000/00000 → next cycle o_valid=1, o_count=0, flags 0. State→S_TRACK.
- Sweep 0..99 and wrap to 00 with LOCK_STEPS=4 → o_count tracks the sequence, 99→0 raises no error, o_locked=1 from the 4th step on.
- Sample tens=00000, ones=00101 → o_ones_bcd=F, o_count=7F, o_err_code=1, o_locked=0, state S_EMPTY. The next legal sample is accepted without o_err_seq.
- From count 23, sample 25 → o_err_seq=1, o_locked=0. Then 26, 27, 28, 29 → o_locked=1 after 29.
- Sample 47 three times, then 48 → no errors. Step counter advances only on 48.
- Assert i_clr_err together with a skipped step → o_err_seq remains 1. i_clr_err alone next cycle → 0. i_rst mid-sweep → all outputs 0 next cycle.
